bus_generator_arbiter: RTL and testbench

Shared-bus generator and arbiter (`bs_gnrtr_n_rbtr`). It connects `drvrs` devices over `bits` independent parallel buses. Each device exposes a first-word-fall-through FIFO (`pndng`/`pop`/`D_pop`) to the bus. On every bus the block picks one pending device round-robin, pops its packet, decodes the 8-bit destination header, and pushes the packet into the destination device(s). It sits between the device-side FIFOs and is wrapped by the `bus_if` interface in the verification environment.

---
 rtl/bus_generator_arbiter_pkg.sv | 22 ++
 rtl/bus_generator_arbiter_bus_lane.sv | 108 ++++++++++
 rtl/bus_generator_arbiter.sv | 36 +++
 tb/tb_bus_generator_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_generator_arbiter_pkg.sv
// rtl/bus_generator_arbiter_pkg.sv - shared types, constants and header helper for the bus arbiter
package bus_generator_arbiter_pkg;

  // Per-lane transaction phases: grant/latch, dequeue strobe, delivery strobe
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_PUSH = 2'd2
  } lane_state_t;

  // Destination ID occupies the top ID_W bits of every packet
  localparam int ID_W      = 8;
  // Widest packet the header helper accepts (callers zero-extend into it)
  localparam int MAX_PKT_W = 1024;

  // Extract the destination ID from a packet of pkt_w bits
  function automatic logic [ID_W-1:0] dest_id(input logic [MAX_PKT_W-1:0] pkt,
                                               input int                  pkt_w);
    return ID_W'(pkt >> (pkt_w - ID_W));
  endfunction

endpackage

// File: rtl/bus_generator_arbiter_bus_lane.sv
// rtl/bus_generator_arbiter_bus_lane.sv - one bus lane: round-robin grant, pop, decode and push
module bus_generator_arbiter_bus_lane
  import bus_generator_arbiter_pkg::*;
#(
  parameter int              drvrs     = 4,
  parameter int              pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = {ID_W{1'b1}}
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [drvrs-1:0]                pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]                pop,
  output logic [drvrs-1:0]                push,
  output logic [drvrs-1:0][pckg_sz-1:0]   D_push
);

  localparam int IDX_W = (drvrs > 1) ? $clog2(drvrs) : 1;

  lane_state_t          state_q, state_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [pckg_sz-1:0]   data_q, data_d;
  logic [pckg_sz-1:0]   dpush_q, dpush_d;
  logic [drvrs-1:0]     pop_d, push_d;
  logic                 found;
  logic [IDX_W-1:0]     pick, cand_idx;
  logic [ID_W-1:0]      id;

  // Next-state logic: round-robin search, header decode and strobe generation
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    data_d   = data_q;
    dpush_d  = dpush_q;
    pop_d    = '0;
    push_d   = '0;
    found    = 1'b0;
    pick     = '0;
    cand_idx = '0;
    id       = dest_id(MAX_PKT_W'(data_q), pckg_sz);

    // First pending device strictly after the previous winner, wrapping around
    for (int i = 1; i <= drvrs; i++) begin
      cand_idx = IDX_W'((int'(last_q) + i) % drvrs);
      if (!found && pndng[cand_idx]) begin
        found = 1'b1;
        pick  = cand_idx;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d     = pick;
          data_d      = D_pop[pick];
          pop_d[pick] = 1'b1;
          state_d     = ST_POP;
        end
      end
      ST_POP: begin
        // Unicast wins over broadcast; unknown IDs yield an empty mask (drop)
        for (int d = 0; d < drvrs; d++) begin
          if (int'(id) < drvrs)
            push_d[d] = (int'(id) == d);
          else if (id == broadcast)
            push_d[d] = (d != int'(grant_q));
        end
        dpush_d = data_q;
        state_d = ST_PUSH;
      end
      ST_PUSH: begin
        last_d  = grant_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any in-flight packet
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(drvrs - 1);
      data_q  <= '0;
      dpush_q <= '0;
      pop     <= '0;
      push    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      data_q  <= data_d;
      dpush_q <= dpush_d;
      pop     <= pop_d;
      push    <= push_d;
    end
  end

  // Every device on the lane sees the same delivered packet
  always_comb begin
    for (int d = 0; d < drvrs; d++)
      D_push[d] = dpush_q;
  end

endmodule

// File: rtl/bus_generator_arbiter.sv
// rtl/bus_generator_arbiter.sv - multi-lane shared-bus generator and arbiter top
module bus_generator_arbiter
  import bus_generator_arbiter_pkg::*;
#(
  parameter int              bits      = 1,
  parameter int              drvrs     = 4,
  parameter int              pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = {ID_W{1'b1}}
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [bits-1:0][drvrs-1:0]                pndng,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]   D_pop,
  output logic [bits-1:0][drvrs-1:0]                pop,
  output logic [bits-1:0][drvrs-1:0]                push,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]   D_push
);

  // Lanes share nothing but the clock and reset
  for (genvar l = 0; l < bits; l++) begin : g_lane
    bus_generator_arbiter_bus_lane #(
      .drvrs     (drvrs),
      .pckg_sz   (pckg_sz),
      .broadcast (broadcast)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .pndng  (pndng[l]),
      .D_pop  (D_pop[l]),
      .pop    (pop[l]),
      .push   (push[l]),
      .D_push (D_push[l])
    );
  end

endmodule

// File: tb/tb_bus_generator_arbiter.sv
// tb/tb_bus_generator_arbiter.sv - self-checking bench for bus_generator_arbiter
module tb_bus_generator_arbiter;

  localparam int BITS = 1;
  localparam int NDEV = 6;
  localparam int PW   = 16;

  logic clk = 1'b0;
  logic reset;
  logic [BITS-1:0][NDEV-1:0]         pndng, pop, push;
  logic [BITS-1:0][NDEV-1:0][PW-1:0] D_pop, D_push;

  bus_generator_arbiter #(
    .bits      (BITS),
    .drvrs     (NDEV),
    .pckg_sz   (PW),
    .broadcast (8'hFF)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .pndng  (pndng),
    .D_pop  (D_pop),
    .pop    (pop),
    .push   (push),
    .D_push (D_push)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  // Device-side FIFOs feeding the lane
  logic [PW-1:0] fifo [NDEV][$];

  // Transaction-level reference model
  int              m_last  = NDEV - 1;
  int              m_free  = 0;
  logic [NDEV-1:0] m_pop   = '0;
  logic [NDEV-1:0] m_push  = '0;
  logic [PW-1:0]   m_dpush = '0;
  bit              sched_valid = 1'b0;
  logic [NDEV-1:0] sched_mask  = '0;
  logic [PW-1:0]   sched_data  = '0;

  logic [NDEV-1:0] obs_pop, obs_push;
  logic [PW-1:0]   obs_dpush;

  function automatic logic [NDEV-1:0] route(input logic [PW-1:0] pkt, input int src);
    int id;
    id = int'(pkt[PW-1 -: 8]);
    if (id < NDEV) return NDEV'(1) << id;
    if (id == 255) return {NDEV{1'b1}} & ~(NDEV'(1) << src);
    return '0;
  endfunction

  function automatic int onehot_idx(input logic [NDEV-1:0] v);
    for (int d = 0; d < NDEV; d++) if (v[d]) return d;
    return -1;
  endfunction

  task automatic drive_inputs();
    for (int d = 0; d < NDEV; d++) begin
      pndng[0][d] = (fifo[d].size() > 0);
      D_pop[0][d] = (fifo[d].size() > 0) ? fifo[d][0] : '0;
    end
  endtask

  // One clock: advance the model at the edge, compare all outputs, redrive FIFOs
  task automatic step();
    int g;
    @(posedge clk);
    cyc++;
    m_pop  = '0;
    m_push = '0;
    if (reset) begin
      m_last      = NDEV - 1;
      m_free      = cyc + 1;
      m_dpush     = '0;
      sched_valid = 1'b0;
    end else begin
      if (sched_valid) begin
        m_push      = sched_mask;
        m_dpush     = sched_data;
        sched_valid = 1'b0;
      end
      if (cyc >= m_free) begin
        g = -1;
        for (int i = 1; i <= NDEV; i++)
          if (g < 0 && fifo[(m_last + i) % NDEV].size() > 0) g = (m_last + i) % NDEV;
        if (g >= 0) begin
          m_pop       = NDEV'(1) << g;
          sched_data  = fifo[g].pop_front();
          sched_mask  = route(sched_data, g);
          sched_valid = 1'b1;
          m_last      = g;
          m_free      = cyc + 3;
        end
      end
    end
    #1;
    obs_pop   = pop[0];
    obs_push  = push[0];
    obs_dpush = D_push[0][0];
    checks++;
    if (pop[0] !== m_pop) $display("FAIL model_pop cyc %0d: got %b expected %b", cyc, pop[0], m_pop);
    else passed++;
    checks++;
    if (push[0] !== m_push) $display("FAIL model_push cyc %0d: got %b expected %b", cyc, push[0], m_push);
    else passed++;
    for (int d = 0; d < NDEV; d++) begin
      checks++;
      if (D_push[0][d] !== m_dpush)
        $display("FAIL model_dpush[%0d] cyc %0d: got %h expected %h", d, cyc, D_push[0][d], m_dpush);
      else passed++;
    end
    drive_inputs();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n < 200 && (fifo[0].size() + fifo[1].size() + fifo[2].size() +
                       fifo[3].size() + fifo[4].size() + fifo[5].size()) > 0) begin
      step();
      n++;
    end
    repeat (4) step();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (pop[0] !== '0 || push[0] !== '0 || D_push[0] !== '0)
      $display("FAIL reset_outputs: got pop=%b push=%b dpush=%h expected all zero", pop[0], push[0], D_push[0]);
    else passed++;
    repeat (3) begin
      step();
      checks++;
      if (obs_pop !== '0 || obs_push !== '0)
        $display("FAIL reset_idle: got pop=%b push=%b expected 0", obs_pop, obs_push);
      else passed++;
    end
  endtask

  task automatic test_single();
    fifo[2].push_back(16'h04AB);
    drive_inputs();
    step();
    checks++;
    if (obs_pop !== 6'b000100 || obs_push !== '0)
      $display("FAIL single_pop: got pop=%b push=%b expected pop=000100 push=0", obs_pop, obs_push);
    else passed++;
    step();
    checks++;
    if (obs_pop !== '0 || obs_push !== 6'b010000 || obs_dpush !== 16'h04AB)
      $display("FAIL single_push: got pop=%b push=%b data=%h expected 0/010000/04ab", obs_pop, obs_push, obs_dpush);
    else passed++;
    step();
    checks++;
    if (obs_push !== '0)
      $display("FAIL single_push_len: got push=%b expected 0", obs_push);
    else passed++;
    drain();
  endtask

  task automatic test_round_robin();
    int              grants[$];
    logic [PW-1:0]   datas[$];
    int              exp_g[4]  = '{0, 3, 5, 0};
    logic [PW-1:0]   exp_d[4]  = '{16'h0110, 16'h0120, 16'h0130, 16'h0140};
    int n;
    apply_reset();
    fifo[0].push_back(16'h0110); fifo[0].push_back(16'h0140);
    fifo[3].push_back(16'h0120); fifo[3].push_back(16'h0150);
    fifo[5].push_back(16'h0130); fifo[5].push_back(16'h0160);
    drive_inputs();
    n = 0;
    while (datas.size() < 4 && n < 30) begin
      step();
      n++;
      if (obs_pop !== '0) grants.push_back(onehot_idx(obs_pop));
      if (obs_push !== '0) begin
        datas.push_back(obs_dpush);
        checks++;
        if (obs_push !== 6'b000010) $display("FAIL rr_push_mask: got %b expected 000010", obs_push);
        else passed++;
      end
    end
    checks++;
    if (datas.size() < 4 || grants.size() < 4)
      $display("FAIL rr_timeout: got %0d pushes expected 4", datas.size());
    else begin
      passed++;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (grants[k] !== exp_g[k] || datas[k] !== exp_d[k])
          $display("FAIL rr_order[%0d]: got dev %0d data %h expected dev %0d data %h",
                   k, grants[k], datas[k], exp_g[k], exp_d[k]);
        else passed++;
      end
    end
    drain();
  endtask

  task automatic test_broadcast();
    int n;
    fifo[1].push_back(16'hFF5A);
    drive_inputs();
    n = 0;
    do begin step(); n++; end while (obs_push === '0 && n < 10);
    checks++;
    if (obs_push !== 6'b111101) $display("FAIL bcast_mask: got %b expected 111101", obs_push);
    else passed++;
    for (int d = 0; d < NDEV; d++) begin
      checks++;
      if (D_push[0][d] !== 16'hFF5A) $display("FAIL bcast_data[%0d]: got %h expected ff5a", d, D_push[0][d]);
      else passed++;
    end
    drain();
  endtask

  task automatic test_drop();
    int n;
    fifo[0].push_back(16'h0933);
    drive_inputs();
    n = 0;
    do begin step(); n++; end while (obs_pop === '0 && n < 10);
    checks++;
    if (obs_pop !== 6'b000001) $display("FAIL drop_pop: got %b expected 000001", obs_pop);
    else passed++;
    repeat (4) begin
      step();
      checks++;
      if (obs_push !== '0) $display("FAIL drop_push: got %b expected 0", obs_push);
      else passed++;
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int n;
    fifo[3].push_back(16'h0211);
    drive_inputs();
    n = 0;
    do begin step(); n++; end while (obs_pop !== 6'b001000 && n < 10);
    checks++;
    if (obs_pop !== 6'b001000) $display("FAIL rmid_pop: got %b expected 001000", obs_pop);
    else passed++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (obs_push !== '0 || obs_pop !== '0) $display("FAIL rmid_abort: got push=%b pop=%b expected 0", obs_push, obs_pop);
    else passed++;
    fifo[4].push_back(16'h0077);
    drive_inputs();
    step();
    checks++;
    if (obs_pop !== 6'b010000) $display("FAIL rmid_idle: got pop=%b expected 010000", obs_pop);
    else passed++;
    step();
    checks++;
    if (obs_push !== 6'b000001 || obs_dpush !== 16'h0077)
      $display("FAIL rmid_next: got push=%b data=%h expected 000001/0077", obs_push, obs_dpush);
    else passed++;
    drain();
  endtask

  task automatic test_random();
    int d, sel;
    logic [7:0] id;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        d   = $urandom_range(0, NDEV - 1);
        sel = $urandom_range(0, 9);
        if (sel < 6)       id = 8'(sel);
        else if (sel < 8)  id = 8'hFF;
        else               id = 8'($urandom_range(6, 254));
        fifo[d].push_back({id, 8'($urandom)});
        drive_inputs();
      end
      step();
    end
    drain();
  endtask

  initial begin
    reset = 1'b1;
    drive_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_broadcast();
    test_drop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
